free_request_queue: RTL and testbench

- Parametrised deferred-free queue between the core's free() path and the memory allocator.
- Accepts free-address requests with a one-cycle completion pulse and stores them in a DEPTH-entry circular buffer.
- Drains entries to the allocator over a valid/ack handshake, only while the allocator reports idle.
- Adds flush, exact full/empty/count status, and a stall counter for profiling.

---
 rtl/free_queue_pkg.sv | 19 +
 rtl/sram_dual_port.sv | 24 ++
 rtl/free_request_queue.sv | 146 ++++++++++++++
 tb/tb_free_request_queue.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/free_queue_pkg.sv
// Shared types and constants for the deferred-free queue.
// Drain FSM encoding, gap-counter sizing and count-width helper.
package free_queue_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2
    } drain_state_e;

    localparam int DRAIN_GAP_DEFAULT = 2;
    localparam int GAP_W             = 3;

    // Count must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int count_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/sram_dual_port.sv
// Simple dual-port RAM: port A registered read, port B write; one-cycle read latency.
// No backpressure; contents are not reset.
module sram_dual_port #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 7
) (
    input  logic                     clk,
    input  logic [RAM_ADDR_BITS-1:0] addr_a,
    output logic [RAM_WIDTH-1:0]     dout_a,
    input  logic                     we_b,
    input  logic [RAM_ADDR_BITS-1:0] addr_b,
    input  logic [RAM_WIDTH-1:0]     din_b
);

    logic [RAM_WIDTH-1:0] mem [0:(1 << RAM_ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we_b) begin
            mem[addr_b] <= din_b;
        end
        dout_a <= mem[addr_a];
    end

endmodule

// File: rtl/free_request_queue.sv
// Deferred-free queue: accept->free_finish 1 cycle, launch->free_request_o 2 cycles.
// Backpressure: full withholds free_finish (requester holds); drain holds until free_ack_i.
module free_request_queue
    import free_queue_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 7,
    parameter int DRAIN_GAP  = DRAIN_GAP_DEFAULT,
    parameter int STALL_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                free_request_i,
    input  logic [ADDR_W-1:0]   free_address_i,
    output logic                free_finish,
    input  logic                idle,
    input  logic                free_ack_i,
    input  logic                flush_i,
    output logic                free_request_o,
    output logic [ADDR_W-1:0]   free_address_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEPTH_LOG2:0] count_o,
    output logic [STALL_W-1:0]  stall_cnt_o
);

    localparam int                 CNT_W   = count_width(DEPTH_LOG2);
    localparam logic [CNT_W-1:0]   DEPTH   = CNT_W'(1 << DEPTH_LOG2);
    localparam logic [GAP_W-1:0]   GAP_MAX = GAP_W'(DRAIN_GAP);

    drain_state_e            state_q;
    drain_state_e            state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [GAP_W-1:0]        gap;
    logic [STALL_W-1:0]      stall_cnt;
    logic [ADDR_W-1:0]       ram_rd_dat;
    logic                    accept;
    logic                    launch;
    logic                    load;
    logic                    pop;

    assign full_o         = (count == DEPTH);
    assign empty_o        = (count == '0);
    assign count_o        = count;
    assign stall_cnt_o    = stall_cnt;
    assign free_request_o = (state_q == PRESENT);

    // !free_finish keeps a still-held request from being stored twice.
    assign accept = free_request_i && !full_o && !free_finish && !flush_i;
    assign launch = idle && !empty_o && (gap == GAP_MAX);

    sram_dual_port #(
        .RAM_WIDTH     (ADDR_W),
        .RAM_ADDR_BITS (DEPTH_LOG2)
    ) u_ram (
        .clk    (clk),
        .addr_a (rd_ptr),
        .dout_a (ram_rd_dat),
        .we_b   (accept),
        .addr_b (wr_ptr),
        .din_b  (free_address_i)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                load    = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (free_ack_i) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            load    = 1'b0;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            gap            <= '0;
            stall_cnt      <= '0;
            free_finish    <= 1'b0;
            free_address_o <= '0;
        end else begin
            free_finish <= accept;
            if (free_request_i && full_o && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
            if (load) begin
                free_address_o <= ram_rd_dat;
            end
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                gap    <= '0;
            end else begin
                if (accept) begin
                    wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                end
                unique case ({accept, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
                if (accept) begin
                    gap <= '0;
                end else if (gap != GAP_MAX) begin
                    gap <= gap + GAP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_free_request_queue.sv
// Directed bench for free_request_queue (DEPTH=4, DRAIN_GAP=2) with a drain-order scoreboard.
module tb_free_request_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        free_request_i;
    logic [31:0] free_address_i;
    logic        free_finish;
    logic        idle;
    logic        free_ack_i;
    logic        flush_i;
    logic        free_request_o;
    logic [31:0] free_address_o;
    logic        full_o;
    logic        empty_o;
    logic [2:0]  count_o;
    logic [15:0] stall_cnt_o;

    int          checks = 0;
    int          errors = 0;
    int          over_count = 0;
    logic [31:0] sb[$];

    free_request_queue #(
        .ADDR_W     (32),
        .DEPTH_LOG2 (2),
        .DRAIN_GAP  (2),
        .STALL_W    (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .free_request_i (free_request_i),
        .free_address_i (free_address_i),
        .free_finish    (free_finish),
        .idle           (idle),
        .free_ack_i     (free_ack_i),
        .flush_i        (flush_i),
        .free_request_o (free_request_o),
        .free_address_o (free_address_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .count_o        (count_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drain monitor: an ack seen mid-cycle completes at the next edge unless flush/rst win.
    always @(negedge clk) begin
        if (!rst && count_o > 3'd4) over_count++;
        if (!rst && !flush_i && free_request_o && free_ack_i) begin
            if (sb.size() == 0) begin
                check("drain_unexpected", 64'(free_address_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("drain_order", 64'(free_address_o), 64'(sb.pop_front()));
            end
        end
    end

    task automatic wait_finish(input logic [31:0] addr, input int budget);
        logic got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (free_finish) begin
                got = 1'b1;
                break;
            end
        end
        check("enqueue_finish", 64'(got), 64'd1);
        if (got) sb.push_back(addr);
        free_request_i = 1'b0;
    endtask

    task automatic enq(input logic [31:0] addr);
        free_request_i = 1'b1;
        free_address_i = addr;
        wait_finish(addr, 20);
    endtask

    task automatic wait_request(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (free_request_o) break;
            tick();
        end
        check("request_timeout", 64'(free_request_o), 64'd1);
    endtask

    task automatic wait_drain(input int budget);
        logic done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && count_o == 3'd0 && !free_request_o) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    initial begin
        logic [31:0] held;
        int          saw_req;

        rst = 1'b1; free_request_i = 1'b0; free_address_i = '0; idle = 1'b0;
        free_ack_i = 1'b0; flush_i = 1'b0;
        tick(); tick(); tick();
        check("rst_finish", 64'(free_finish), 64'd0);
        check("rst_req_o", 64'(free_request_o), 64'd0);
        check("rst_addr_o", 64'(free_address_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_stall", 64'(stall_cnt_o), 64'd0);
        rst = 1'b0;

        // Single free: accept edge, then gap 0,1,2 -> launch -> fetch -> present.
        idle = 1'b1; free_ack_i = 1'b1;
        free_request_i = 1'b1; free_address_i = 32'h8000_1000;
        tick();
        check("single_finish", 64'(free_finish), 64'd1);
        check("single_count1", 64'(count_o), 64'd1);
        sb.push_back(32'h8000_1000);
        free_request_i = 1'b0;
        tick();
        check("single_finish_pulse", 64'(free_finish), 64'd0);
        tick(); tick();
        check("single_req_early", 64'(free_request_o), 64'd0);
        tick();
        check("single_req_on_time", 64'(free_request_o), 64'd1);
        check("single_addr", 64'(free_address_o), 64'h8000_1000);
        tick();
        check("single_req_drop", 64'(free_request_o), 64'd0);
        check("single_count0", 64'(count_o), 64'd0);

        // Fill to full, then a held fifth request stalls.
        idle = 1'b0; free_ack_i = 1'b0;
        enq(32'h10); enq(32'h20); enq(32'h30); enq(32'h40);
        check("fill_full", 64'(full_o), 64'd1);
        check("fill_count", 64'(count_o), 64'd4);
        free_request_i = 1'b1; free_address_i = 32'h50;
        for (int i = 0; i < 6; i++) tick();
        check("fill_no_finish", 64'(free_finish), 64'd0);
        check("fill_stall6", 64'(stall_cnt_o), 64'd6);
        idle = 1'b1; free_ack_i = 1'b1;
        wait_finish(32'h50, 30);
        // Launch, fetch and present cycles of the first drain are still blocked: 6 + 3.
        check("fill_stall_final", 64'(stall_cnt_o), 64'd9);
        wait_drain(80);

        // Interleaved enqueue/drain across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            enq(32'h1000 + 32'(i));
            if (i % 2 == 1) wait_drain(40);
        end
        wait_drain(40);

        // Presented entry holds while idle drops and ack is late.
        free_ack_i = 1'b0;
        enq(32'hABCD_0000);
        wait_request(20);
        idle = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_req", 64'(free_request_o), 64'd1);
            check("hold_addr", 64'(free_address_o), 64'hABCD_0000);
        end
        free_ack_i = 1'b1;
        tick();
        check("hold_released", 64'(free_request_o), 64'd0);
        free_ack_i = 1'b0;

        // Simultaneous accept and pop at count 2.
        enq(32'hA1); enq(32'hB2);
        idle = 1'b1;
        wait_request(20);
        check("simul_count_pre", 64'(count_o), 64'd2);
        free_request_i = 1'b1; free_address_i = 32'hC3; sb.push_back(32'hC3);
        free_ack_i = 1'b1;
        tick();
        check("simul_finish", 64'(free_finish), 64'd1);
        check("simul_count", 64'(count_o), 64'd2);
        free_request_i = 1'b0;
        wait_drain(60);

        // Flush during PRESENT with three queued; request in the flush cycle is dropped.
        idle = 1'b0; free_ack_i = 1'b0;
        enq(32'hD1); enq(32'hD2); enq(32'hD3);
        idle = 1'b1;
        wait_request(20);
        check("flush_count_pre", 64'(count_o), 64'd3);
        flush_i = 1'b1; free_request_i = 1'b1; free_address_i = 32'hEE;
        tick();
        flush_i = 1'b0; free_request_i = 1'b0;
        sb.delete();
        check("flush_req_o", 64'(free_request_o), 64'd0);
        check("flush_empty", 64'(empty_o), 64'd1);
        check("flush_no_finish", 64'(free_finish), 64'd0);
        check("flush_stall_kept", 64'(stall_cnt_o), 64'd9);
        free_ack_i = 1'b1;
        saw_req = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (free_request_o) saw_req++;
        end
        check("flush_no_drain", 64'(saw_req), 64'd0);

        // Reset in the middle of an enqueue.
        idle = 1'b0; free_ack_i = 1'b0;
        enq(32'hF1);
        held = 32'hF2;
        free_request_i = 1'b1; free_address_i = held; rst = 1'b1;
        tick();
        check("rst2_finish", 64'(free_finish), 64'd0);
        check("rst2_count", 64'(count_o), 64'd0);
        check("rst2_empty", 64'(empty_o), 64'd1);
        check("rst2_req_o", 64'(free_request_o), 64'd0);
        check("rst2_addr_o", 64'(free_address_o), 64'd0);
        check("rst2_stall", 64'(stall_cnt_o), 64'd0);
        rst = 1'b0; free_request_i = 1'b0;
        sb.delete();
        tick();

        check("count_bound", 64'(over_count), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
